// File: rtl/usb_fs_out_pe_pingpong.sv
// usb_fs_out_pe_pingpong: full-speed OUT/SETUP protocol engine
// with per-endpoint packet slots (ping-pong when NUM_BUFS = 2).
module usb_fs_out_pe_pingpong #(
    parameter int NUM_OUT_EPS         = 1,
    parameter int MAX_OUT_PACKET_SIZE = 64,
    parameter int NUM_BUFS            = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_OUT_EPS-1:0] reset_ep,
    input  logic [6:0]             dev_addr,
    output logic [NUM_OUT_EPS-1:0] out_ep_data_avail,
    output logic [NUM_OUT_EPS-1:0] out_ep_setup,
    input  logic [NUM_OUT_EPS-1:0] out_ep_data_get,
    input  logic [NUM_OUT_EPS-1:0] out_ep_grant,
    output logic [7:0]             out_ep_data,
    output logic [6:0]             out_ep_len,
    input  logic [NUM_OUT_EPS-1:0] out_ep_stall,
    output logic [NUM_OUT_EPS-1:0] out_ep_acked,
    input  logic                   rx_pkt_start,
    input  logic                   rx_pkt_end,
    input  logic                   rx_pkt_valid,
    input  logic [3:0]             rx_pid,
    input  logic [6:0]             rx_addr,
    input  logic [3:0]             rx_endp,
    input  logic                   rx_data_put,
    input  logic [7:0]             rx_data,
    output logic                   tx_pkt_start,
    output logic [3:0]             tx_pid,
    input  logic                   tx_pkt_end
);

    localparam int EW    = (NUM_OUT_EPS > 1) ? $clog2(NUM_OUT_EPS) : 1;
    localparam int AW    = $clog2(MAX_OUT_PACKET_SIZE);
    localparam int DEPTH = NUM_OUT_EPS * NUM_BUFS * MAX_OUT_PACKET_SIZE;
    localparam int MW    = $clog2(DEPTH);

    localparam logic [7:0] OVF_PTR = 8'(MAX_OUT_PACKET_SIZE + 2);
    localparam logic [7:0] MAX_PTR = 8'(MAX_OUT_PACKET_SIZE);

    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    typedef enum logic [1:0] {
        X_IDLE, X_RCVD_OUT, X_DATA_START, X_DATA_END
    } xfr_e;

    typedef enum logic [1:0] {
        SLOT_EMPTY, SLOT_FILLING, SLOT_FULL
    } slot_e;

    typedef enum logic [1:0] {
        ACT_NONE, ACT_STALL, ACT_NAK, ACT_ACCEPT
    } act_e;

    xfr_e             xfr_q;
    act_e             act_q;
    act_e             act_d;
    logic             decided_q;
    logic [EW-1:0]    ep_q;
    logic             setup_q;
    logic [7:0]       ptr_q;
    logic             ovf_q;

    slot_e            slot_st_q    [NUM_OUT_EPS][NUM_BUFS];
    logic [6:0]       slot_len_q   [NUM_OUT_EPS][NUM_BUFS];
    logic             slot_setup_q [NUM_OUT_EPS][NUM_BUFS];
    logic [NUM_OUT_EPS-1:0] toggle_q;
    logic [NUM_OUT_EPS-1:0] wr_idx_q;
    logic [NUM_OUT_EPS-1:0] rd_idx_q;
    logic [6:0]       rptr_q       [NUM_OUT_EPS];

    logic [7:0]       mem_q        [DEPTH];

    logic             token_ok_d;
    logic [EW-1:0]    rx_ep_d;
    logic             data_pid_ok_d;
    logic             ovf_now_d;
    logic [6:0]       rx_len_d;
    slot_e            wr_st_d;
    logic [EW-1:0]    gidx_d;
    logic             mem_we_d;
    logic [MW-1:0]    waddr_d;
    logic [MW-1:0]    raddr_d;
    logic [NUM_OUT_EPS-1:0] head_last_d;
    logic             unused_tx_end;

    assign unused_tx_end = tx_pkt_end;

    function automatic logic next_idx(input logic i);
        return (NUM_BUFS == 2) ? ~i : 1'b0;
    endfunction

    function automatic logic [MW-1:0] addr_of(
        input logic [EW-1:0] e,
        input logic          s,
        input logic [AW-1:0] p
    );
        int a;
        a = (int'(e) * NUM_BUFS + int'(s)) * MAX_OUT_PACKET_SIZE + int'(p);
        return MW'(a);
    endfunction

    // Token/data qualification, handshake decision and buffer addressing
    always_comb begin
        token_ok_d = rx_pkt_end && rx_pkt_valid
                  && (rx_pid[1:0] == 2'b01)
                  && (rx_pid[3:2] == 2'b00 || rx_pid[3:2] == 2'b11)
                  && (rx_addr == dev_addr)
                  && ({1'b0, rx_endp} < 5'(NUM_OUT_EPS));
        rx_ep_d       = EW'(rx_endp);
        data_pid_ok_d = rx_pkt_valid && (rx_pid[2:0] == 3'b011);
        ovf_now_d     = ovf_q || (rx_data_put && act_q == ACT_ACCEPT
                                  && ptr_q == OVF_PTR);
        rx_len_d      = (ptr_q >= 8'd2) ? 7'(ptr_q - 8'd2) : 7'd0;

        wr_st_d = slot_st_q[ep_q][wr_idx_q[ep_q]];
        act_d   = ACT_ACCEPT;
        if (out_ep_stall[ep_q] && !setup_q) begin
            act_d = ACT_STALL;
        end else if (!setup_q && wr_st_d != SLOT_EMPTY) begin
            act_d = ACT_NAK;
        end

        gidx_d = '0;
        for (int e = 0; e < NUM_OUT_EPS; e++) begin
            if (out_ep_grant[e]) gidx_d = EW'(e);
        end

        mem_we_d = (xfr_q == X_DATA_START) && rx_data_put
                && (act_q == ACT_ACCEPT) && !ovf_q && (ptr_q < MAX_PTR);
        waddr_d  = addr_of(ep_q, wr_idx_q[ep_q], ptr_q[AW-1:0]);
        raddr_d  = addr_of(gidx_d, rd_idx_q[gidx_d],
                           rptr_q[gidx_d][AW-1:0]);

        for (int e = 0; e < NUM_OUT_EPS; e++) begin
            out_ep_data_avail[e] = (slot_st_q[e][rd_idx_q[e]] == SLOT_FULL);
            out_ep_setup[e]      = out_ep_data_avail[e]
                                && slot_setup_q[e][rd_idx_q[e]];
            head_last_d[e]       = (rptr_q[e] + 7'd1)
                                >= slot_len_q[e][rd_idx_q[e]];
        end
        out_ep_len = slot_len_q[gidx_d][rd_idx_q[gidx_d]];
    end

    // Payload storage; CRC bytes past the slot end are dropped
    always_ff @(posedge clk) begin
        if (mem_we_d) mem_q[waddr_d] <= rx_data;
    end

    // Registered read port for the granted endpoint
    always_ff @(posedge clk) begin
        if (reset) out_ep_data <= 8'd0;
        else       out_ep_data <= mem_q[raddr_d];
    end

    // Transfer FSM, slot bookkeeping and consumer read side
    always_ff @(posedge clk) begin
        if (reset) begin
            xfr_q        <= X_IDLE;
            act_q        <= ACT_NONE;
            decided_q    <= 1'b0;
            ep_q         <= '0;
            setup_q      <= 1'b0;
            ptr_q        <= 8'd0;
            ovf_q        <= 1'b0;
            tx_pkt_start <= 1'b0;
            tx_pid       <= 4'd0;
            out_ep_acked <= '0;
            toggle_q     <= '0;
            wr_idx_q     <= '0;
            rd_idx_q     <= '0;
            for (int e = 0; e < NUM_OUT_EPS; e++) begin
                rptr_q[e] <= 7'd0;
                for (int s = 0; s < NUM_BUFS; s++) begin
                    slot_st_q[e][s]    <= SLOT_EMPTY;
                    slot_len_q[e][s]   <= 7'd0;
                    slot_setup_q[e][s] <= 1'b0;
                end
            end
        end else begin
            tx_pkt_start <= 1'b0;
            tx_pid       <= 4'd0;
            out_ep_acked <= '0;

            for (int e = 0; e < NUM_OUT_EPS; e++) begin
                if (out_ep_data_get[e] && out_ep_data_avail[e]) begin
                    if (head_last_d[e]) begin
                        slot_st_q[e][rd_idx_q[e]]  <= SLOT_EMPTY;
                        slot_len_q[e][rd_idx_q[e]] <= 7'd0;
                        rd_idx_q[e] <= next_idx(rd_idx_q[e]);
                        rptr_q[e]   <= 7'd0;
                    end else begin
                        rptr_q[e] <= rptr_q[e] + 7'd1;
                    end
                end
            end

            unique case (xfr_q)
                X_IDLE: begin
                    if (token_ok_d) begin
                        xfr_q     <= X_RCVD_OUT;
                        ep_q      <= rx_ep_d;
                        setup_q   <= (rx_pid[3:2] == 2'b11);
                        decided_q <= 1'b0;
                        act_q     <= ACT_NONE;
                        if (rx_pid[3:2] == 2'b11) toggle_q[rx_ep_d] <= 1'b0;
                    end
                end
                X_RCVD_OUT: begin
                    if (!decided_q) begin
                        decided_q <= 1'b1;
                        act_q     <= act_d;
                        ptr_q     <= 8'd0;
                        ovf_q     <= 1'b0;
                        if (act_d == ACT_ACCEPT) begin
                            slot_st_q[ep_q][wr_idx_q[ep_q]]  <= SLOT_FILLING;
                            slot_len_q[ep_q][wr_idx_q[ep_q]] <= 7'd0;
                            if (wr_idx_q[ep_q] == rd_idx_q[ep_q]) begin
                                rd_idx_q[ep_q] <= rd_idx_q[ep_q];
                                rptr_q[ep_q]   <= 7'd0;
                            end
                        end
                    end
                    if (rx_pkt_start) xfr_q <= X_DATA_START;
                end
                X_DATA_START: begin
                    if (rx_data_put && act_q == ACT_ACCEPT && !ovf_q) begin
                        if (ptr_q == OVF_PTR) ovf_q <= 1'b1;
                        else                  ptr_q <= ptr_q + 8'd1;
                    end
                    if (rx_pkt_end) begin
                        xfr_q <= X_IDLE;
                        if (!data_pid_ok_d || ovf_now_d) begin
                            if (act_q == ACT_ACCEPT) begin
                                slot_st_q[ep_q][wr_idx_q[ep_q]] <= SLOT_EMPTY;
                            end
                        end else if (act_q == ACT_ACCEPT
                                     && rx_pid[3] != toggle_q[ep_q]) begin
                            slot_st_q[ep_q][wr_idx_q[ep_q]] <= SLOT_EMPTY;
                            tx_pkt_start <= 1'b1;
                            tx_pid       <= PID_ACK;
                        end else begin
                            xfr_q        <= X_DATA_END;
                            tx_pkt_start <= 1'b1;
                            if (act_q == ACT_STALL) begin
                                tx_pid <= PID_STALL;
                            end else if (act_q == ACT_NAK) begin
                                tx_pid <= PID_NAK;
                            end else begin
                                tx_pid <= PID_ACK;
                                slot_st_q[ep_q][wr_idx_q[ep_q]]    <= SLOT_FULL;
                                slot_len_q[ep_q][wr_idx_q[ep_q]]   <= rx_len_d;
                                slot_setup_q[ep_q][wr_idx_q[ep_q]] <= setup_q;
                                toggle_q[ep_q]     <= ~toggle_q[ep_q];
                                wr_idx_q[ep_q]     <= next_idx(wr_idx_q[ep_q]);
                                out_ep_acked[ep_q] <= 1'b1;
                            end
                        end
                    end
                end
                X_DATA_END: xfr_q <= X_IDLE;
                default:    xfr_q <= X_IDLE;
            endcase

            for (int e = 0; e < NUM_OUT_EPS; e++) begin
                if (reset_ep[e]) begin
                    for (int s = 0; s < NUM_BUFS; s++) begin
                        slot_st_q[e][s]    <= SLOT_EMPTY;
                        slot_len_q[e][s]   <= 7'd0;
                        slot_setup_q[e][s] <= 1'b0;
                    end
                    toggle_q[e] <= 1'b0;
                    wr_idx_q[e] <= 1'b0;
                    rd_idx_q[e] <= 1'b0;
                    rptr_q[e]   <= 7'd0;
                    if (xfr_q != X_IDLE && ep_q == EW'(e)) begin
                        xfr_q           <= X_IDLE;
                        tx_pkt_start    <= 1'b0;
                        tx_pid          <= 4'd0;
                        out_ep_acked[e] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_usb_fs_out_pe_pingpong.sv
// tb_usb_fs_out_pe_pingpong: directed bench for the OUT protocol
// engine with hand-computed handshakes, lengths and payload bytes.
module tb_usb_fs_out_pe_pingpong;

    localparam logic [3:0] OUT_P   = 4'b0001;
    localparam logic [3:0] SETUP_P = 4'b1101;
    localparam logic [3:0] DATA0   = 4'b0011;
    localparam logic [3:0] DATA1   = 4'b1011;
    localparam logic [3:0] ACK     = 4'b0010;
    localparam logic [3:0] NAK     = 4'b1010;
    localparam logic [3:0] STALL   = 4'b1110;
    localparam logic [6:0] ADDR    = 7'h05;

    logic       clk = 1'b0;
    logic       reset;
    logic [0:0] reset_ep;
    logic [6:0] dev_addr;
    logic [0:0] out_ep_data_avail;
    logic [0:0] out_ep_setup;
    logic [0:0] out_ep_data_get;
    logic [0:0] out_ep_grant;
    logic [7:0] out_ep_data;
    logic [6:0] out_ep_len;
    logic [0:0] out_ep_stall;
    logic [0:0] out_ep_acked;
    logic       rx_pkt_start;
    logic       rx_pkt_end;
    logic       rx_pkt_valid;
    logic [3:0] rx_pid;
    logic [6:0] rx_addr;
    logic [3:0] rx_endp;
    logic       rx_data_put;
    logic [7:0] rx_data;
    logic       tx_pkt_start;
    logic [3:0] tx_pid;
    logic       tx_pkt_end;

    int n_chk = 0;
    int n_err = 0;
    int tx_cnt = 0;

    always #5 clk = ~clk;

    usb_fs_out_pe_pingpong #(
        .NUM_OUT_EPS(1),
        .MAX_OUT_PACKET_SIZE(64),
        .NUM_BUFS(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .reset_ep(reset_ep),
        .dev_addr(dev_addr),
        .out_ep_data_avail(out_ep_data_avail),
        .out_ep_setup(out_ep_setup),
        .out_ep_data_get(out_ep_data_get),
        .out_ep_grant(out_ep_grant),
        .out_ep_data(out_ep_data),
        .out_ep_len(out_ep_len),
        .out_ep_stall(out_ep_stall),
        .out_ep_acked(out_ep_acked),
        .rx_pkt_start(rx_pkt_start),
        .rx_pkt_end(rx_pkt_end),
        .rx_pkt_valid(rx_pkt_valid),
        .rx_pid(rx_pid),
        .rx_addr(rx_addr),
        .rx_endp(rx_endp),
        .rx_data_put(rx_data_put),
        .rx_data(rx_data),
        .tx_pkt_start(tx_pkt_start),
        .tx_pid(tx_pid),
        .tx_pkt_end(tx_pkt_end)
    );

    always @(negedge clk) if (tx_pkt_start) tx_cnt++;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic token(input logic [3:0] pid, input logic [6:0] addr,
                         input logic [3:0] ep);
        @(posedge clk); #1 rx_pkt_start = 1'b1;
        @(posedge clk); #1 rx_pkt_start = 1'b0;
        rx_pkt_end = 1'b1; rx_pkt_valid = 1'b1;
        rx_pid = pid; rx_addr = addr; rx_endp = ep;
        @(posedge clk); #1 rx_pkt_end = 1'b0; rx_pkt_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic data_pkt(input logic [3:0] pid, input int n,
                            input logic [7:0] seed, input int rst_at,
                            output logic hs, output logic [3:0] hpid,
                            output logic ackp);
        @(posedge clk); #1 rx_pkt_start = 1'b1;
        @(posedge clk); #1 rx_pkt_start = 1'b0;
        for (int i = 0; i < n + 2; i++) begin
            rx_data_put = 1'b1;
            rx_data = (i < n) ? seed + 8'(i) : 8'hC5 + 8'(i);
            reset_ep = (i == rst_at) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
        end
        reset_ep = 1'b0;
        rx_data_put = 1'b0;
        rx_pkt_end = 1'b1; rx_pkt_valid = 1'b1; rx_pid = pid;
        @(posedge clk); #1 rx_pkt_end = 1'b0; rx_pkt_valid = 1'b0;
        @(negedge clk);
        hs = tx_pkt_start; hpid = tx_pid; ackp = out_ep_acked[0];
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic out_xfer(input logic [3:0] pid, input int n,
                            input logic [7:0] seed, input int rst_at,
                            output logic hs, output logic [3:0] hpid,
                            output logic ackp);
        token(OUT_P, ADDR, 4'd0);
        data_pkt(pid, n, seed, rst_at, hs, hpid, ackp);
    endtask

    task automatic drain(input int n, input logic [7:0] seed,
                         input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (out_ep_data !== seed + 8'(i)) bad++;
            out_ep_data_get = 1'b1;
            @(posedge clk); #1 out_ep_data_get = 1'b0;
            @(posedge clk);
        end
        chk(tag, bad, 0);
    endtask

    initial begin
        logic       hs;
        logic [3:0] hp;
        logic       ak;
        int         c0;

        reset = 1'b1; reset_ep = 1'b0; dev_addr = ADDR;
        out_ep_data_get = 1'b0; out_ep_grant = 1'b1; out_ep_stall = 1'b0;
        rx_pkt_start = 1'b0; rx_pkt_end = 1'b0; rx_pkt_valid = 1'b0;
        rx_pid = 4'd0; rx_addr = 7'd0; rx_endp = 4'd0;
        rx_data_put = 1'b0; rx_data = 8'd0; tx_pkt_end = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_avail", out_ep_data_avail, 0);
        chk("rst_txs", tx_pkt_start, 0);
        chk("rst_txpid", tx_pid, 0);
        chk("rst_acked", out_ep_acked, 0);
        chk("rst_data", out_ep_data, 0);
        chk("rst_len", out_ep_len, 0);
        @(posedge clk); #1 reset = 1'b0;

        // single OUT DATA0, 8 bytes
        out_xfer(DATA0, 8, 8'h10, -1, hs, hp, ak);
        chk("t1_hs", hs, 1);
        chk("t1_pid", hp, ACK);
        chk("t1_acked", ak, 1);
        chk("t1_avail", out_ep_data_avail, 1);
        chk("t1_len", out_ep_len, 8);
        chk("t1_setup", out_ep_setup, 0);
        drain(8, 8'h10, "t1_bytes");
        chk("t1_empty", out_ep_data_avail, 0);

        // ping-pong fill, NAK when full, retry after drain
        out_xfer(DATA1, 8, 8'h20, -1, hs, hp, ak);
        chk("t2_a_pid", hp, ACK);
        out_xfer(DATA0, 8, 8'h30, -1, hs, hp, ak);
        chk("t2_b_pid", hp, ACK);
        out_xfer(DATA1, 8, 8'h40, -1, hs, hp, ak);
        chk("t2_c_pid", hp, NAK);
        chk("t2_c_acked", ak, 0);
        drain(8, 8'h20, "t2_bytes_a");
        chk("t2_avail_b", out_ep_data_avail, 1);
        out_xfer(DATA1, 8, 8'h40, -1, hs, hp, ak);
        chk("t2_retry_pid", hp, ACK);
        chk("t2_retry_acked", ak, 1);
        drain(8, 8'h30, "t2_bytes_b");
        drain(8, 8'h40, "t2_bytes_c");
        chk("t2_empty", out_ep_data_avail, 0);

        // repeated DATA0 is ACKed but discarded
        out_xfer(DATA0, 4, 8'h50, -1, hs, hp, ak);
        chk("t3_pid", hp, ACK);
        out_xfer(DATA0, 4, 8'h60, -1, hs, hp, ak);
        chk("t3_rep_pid", hp, ACK);
        chk("t3_rep_acked", ak, 0);
        chk("t3_len", out_ep_len, 4);
        drain(4, 8'h50, "t3_bytes");
        chk("t3_empty", out_ep_data_avail, 0);

        // STALL, then SETUP overrides it
        out_ep_stall = 1'b1;
        out_xfer(DATA1, 4, 8'h70, -1, hs, hp, ak);
        chk("t4_stall_pid", hp, STALL);
        chk("t4_stall_avail", out_ep_data_avail, 0);
        token(SETUP_P, ADDR, 4'd0);
        data_pkt(DATA0, 8, 8'h80, -1, hs, hp, ak);
        chk("t4_setup_pid", hp, ACK);
        chk("t4_setup_acked", ak, 1);
        chk("t4_setup_flag", out_ep_setup, 1);
        chk("t4_setup_len", out_ep_len, 8);
        out_ep_stall = 1'b0;
        drain(8, 8'h80, "t4_setup_bytes");
        out_xfer(DATA1, 0, 8'h00, -1, hs, hp, ak);
        chk("t4_zlp_pid", hp, ACK);
        chk("t4_zlp_acked", ak, 1);
        chk("t4_zlp_len", out_ep_len, 0);
        chk("t4_zlp_avail", out_ep_data_avail, 1);
        @(negedge clk); out_ep_data_get = 1'b1;
        @(posedge clk); #1 out_ep_data_get = 1'b0;
        @(negedge clk);
        chk("t4_zlp_freed", out_ep_data_avail, 0);

        // max-size packet and oversize packet
        out_xfer(DATA0, 64, 8'h00, -1, hs, hp, ak);
        chk("t5_max_pid", hp, ACK);
        chk("t5_max_len", out_ep_len, 64);
        drain(64, 8'h00, "t5_max_bytes");
        c0 = tx_cnt;
        out_xfer(DATA1, 67, 8'h90, -1, hs, hp, ak);
        chk("t5_ovf_hs", hs, 0);
        chk("t5_ovf_txcnt", tx_cnt - c0, 0);
        chk("t5_ovf_avail", out_ep_data_avail, 0);
        out_xfer(DATA1, 4, 8'hA0, -1, hs, hp, ak);
        chk("t5_after_acked", ak, 1);
        drain(4, 8'hA0, "t5_after_bytes");

        // endpoint reset in the middle of a data packet
        out_xfer(DATA0, 0, 8'h00, -1, hs, hp, ak);
        chk("t6_pre_acked", ak, 1);
        c0 = tx_cnt;
        out_xfer(DATA1, 8, 8'hB0, 3, hs, hp, ak);
        chk("t6_rst_txcnt", tx_cnt - c0, 0);
        chk("t6_rst_avail", out_ep_data_avail, 0);
        out_xfer(DATA0, 3, 8'hC0, -1, hs, hp, ak);
        chk("t6_post_pid", hp, ACK);
        chk("t6_post_acked", ak, 1);
        chk("t6_post_len", out_ep_len, 3);

        // foreign address / endpoint leave the slot alone
        c0 = tx_cnt;
        token(OUT_P, 7'h06, 4'd0);
        data_pkt(DATA1, 2, 8'hE0, -1, hs, hp, ak);
        token(OUT_P, ADDR, 4'd1);
        data_pkt(DATA1, 2, 8'hE8, -1, hs, hp, ak);
        chk("t7_foreign_txcnt", tx_cnt - c0, 0);
        chk("t7_len", out_ep_len, 3);
        drain(3, 8'hC0, "t7_bytes");

        // global reset clears a full slot
        out_xfer(DATA1, 2, 8'hD0, -1, hs, hp, ak);
        chk("t8_pid", hp, ACK);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("t8_avail", out_ep_data_avail, 0);
        chk("t8_len", out_ep_len, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
